// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Full-adder cell built from two half adders, with the two partial carries ORed.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  half_adder ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder; the shared datapath primitive.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell processes one operand bit per clock, LSB first,
// and the completed sum/carry-out are published together with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  // Only WIDTH-1 partial bits are stored; the final bit joins them on the completing edge.
  logic [WIDTH-2:0] part;
  logic [WIDTH-2:0] part_next;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (carry),
    .sum (fa_s),
    .cout(fa_c)
  );

  generate
    if (WIDTH > 2) begin : g_wide
      assign part_next = {fa_s, part[WIDTH-2:1]};
    end else begin : g_narrow
      assign part_next = fa_s;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      part  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            part  <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= fa_c;
          part  <= part_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {fa_s, part};
            cout  <= fa_c;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one full-adder cell across the bits of two WIDTH-bit operands.
- The cell is built from two half_adder instances plus an OR gate.
- Sequences one bit per clock, LSB first, and presents the registered sum/carry-out with a one-cycle done pulse.
- Sits between a requester (start/operand interface) and the shared half_adder datapath; this is the team's first clocked arithmetic block.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      synchronous active-low reset, sampled on rising edge of clk
- start  input   1      request; sampled only in IDLE or DONE
- a      input   WIDTH  operand A, captured on accepted start
- b      input   WIDTH  operand B, captured on accepted start
- cin    input   1      carry-in, captured on accepted start
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse when the result becomes valid
- sum    output  WIDTH  registered result
- cout   output  1      registered carry-out

Behaviour:
- Reset: one clock; reset is synchronous and active-low. When rst_n=0 at a clk edge:
  - state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, internal shift/carry regs=0.
  - Reset has priority over start.
  - Reset mid-RUN aborts the add: no done pulse, sum/cout forced to 0.
- States: IDLE, RUN, DONE (encoding in package).
- IDLE:
  - start=1 -> load opA/opB shift regs from a/b, carry reg from cin, counter=0 -> RUN.
  - Else stay.
- RUN, each cycle:
  - Full-adder cell computes s = opA[0]^opB[0]^carry and c = (opA[0]&opB[0]) | (carry&(opA[0]^opB[0])).
  - s shifts into the MSB of the partial-sum reg (right shift); opA/opB shift right; carry <= c; counter++.
  - When counter==WIDTH-1 on this edge: sum <= final partial sum (including this bit), cout <= c -> DONE.
  - start is ignored throughout RUN; a/b/cin changes have no effect.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted (back-to-back): operands load -> RUN. Otherwise -> IDLE.
- Latency: start accepted at edge E0; done is high in the cycle following edge E(WIDTH). This is WIDTH cycles, throughput WIDTH+1 cycles per add.
- sum/cout update only on the RUN->DONE edge and hold until the next completion or reset. Partial state is never visible on sum.
- busy=1 iff state==RUN. done=1 iff state==DONE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.

Decomposition:
- Package serial_add_pkg:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- Sub-module full_adder:
  - Two existing half_adder instances plus OR on the carries.
  - Ports a, b, cin, sum, cout; purely combinational.
- serial_add_ctrl contains the FSM, counter, shift regs and result regs, and instantiates one full_adder.

Test Plan (WIDTH=8):
1. Reset with rst_n=0 for 2 cycles, start held high -> busy=0, done=0, sum=8'h00, cout=0; no RUN entry while rst_n=0.
2. a=8'hFF, b=8'h01, cin=0, start pulse -> busy high 8 cycles; done pulses 8 cycles after the accept edge with sum=8'h00, cout=1; values hold afterward.
3. a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1. Then a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0.
4. Start a=8'h12, b=8'h34; at RUN cycle 3 pulse start with a=8'hFF, b=8'hFF -> ignored; result sum=8'h46, cout=0, exactly one done pulse.
5. Start a=8'h80, b=8'h80, cin=0; deassert rst_n for 1 cycle at RUN cycle 4 -> no done pulse, sum=0, busy=0. Next start a=8'h01, b=8'h02 -> sum=8'h03.
6. Back-to-back: hold start=1 through the DONE cycle of a 8'h10+8'h20 add (sum=8'h30) with a=8'h80, b=8'h80 -> second done exactly 9 cycles after the first, sum=8'h00, cout=1.
